// File: rtl/morse_symbol_sequencer_pkg.sv
// morse_symbol_sequencer_pkg: shared FSM states and character constants for the Morse sequencer
package morse_symbol_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    WAIT_CLR,
    EMIT_CHAR,
    EMIT_SPACE
  } state_e;
  localparam logic [2:0] MORSE_MAX_ELEMS = 3'd6;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// morse_symbol_sequencer_if: timing-block event handshake plus ready/valid character stream
//  master (sequencer): drives read, out_data, out_valid; receives dot/dash/interchar/interword/writing, out_ready
//  slave  (environment): the reverse
interface morse_symbol_sequencer_if;
  logic       dot;
  logic       dash;
  logic       interchar;
  logic       interword;
  logic       writing;
  logic       read;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport master (
    input  dot, dash, interchar, interword, writing, out_ready,
    output read, out_data, out_valid
  );
  modport slave (
    output dot, dash, interchar, interword, writing, out_ready,
    input  read, out_data, out_valid
  );
endinterface

// File: rtl/morse_symbol_sequencer_decode_rom.sv
// morse_symbol_sequencer_decode_rom: combinational Morse pattern to ASCII lookup (A-Z, 0-9)
//  len_i   element count; bits_i pattern right-aligned, first element in bit len_i-1 (dash=1)
//  hit_o   pattern recognised; ascii_o decoded character (0 on miss)
module morse_symbol_sequencer_decode_rom
  import morse_symbol_sequencer_pkg::*;
(
  input  logic [2:0] len_i,
  input  logic [5:0] bits_i,
  output logic       hit_o,
  output logic [7:0] ascii_o
);
  always_comb begin
    hit_o = 1'b1;
    ascii_o = 8'h00;
    case ({len_i, bits_i})
      {3'd1, 6'b000000}: ascii_o = "E";
      {3'd1, 6'b000001}: ascii_o = "T";
      {3'd2, 6'b000000}: ascii_o = "I";
      {3'd2, 6'b000001}: ascii_o = "A";
      {3'd2, 6'b000010}: ascii_o = "N";
      {3'd2, 6'b000011}: ascii_o = "M";
      {3'd3, 6'b000000}: ascii_o = "S";
      {3'd3, 6'b000001}: ascii_o = "U";
      {3'd3, 6'b000010}: ascii_o = "R";
      {3'd3, 6'b000011}: ascii_o = "W";
      {3'd3, 6'b000100}: ascii_o = "D";
      {3'd3, 6'b000101}: ascii_o = "K";
      {3'd3, 6'b000110}: ascii_o = "G";
      {3'd3, 6'b000111}: ascii_o = "O";
      {3'd4, 6'b000000}: ascii_o = "H";
      {3'd4, 6'b000001}: ascii_o = "V";
      {3'd4, 6'b000010}: ascii_o = "F";
      {3'd4, 6'b000100}: ascii_o = "L";
      {3'd4, 6'b000110}: ascii_o = "P";
      {3'd4, 6'b000111}: ascii_o = "J";
      {3'd4, 6'b001000}: ascii_o = "B";
      {3'd4, 6'b001001}: ascii_o = "X";
      {3'd4, 6'b001010}: ascii_o = "C";
      {3'd4, 6'b001011}: ascii_o = "Y";
      {3'd4, 6'b001100}: ascii_o = "Z";
      {3'd4, 6'b001101}: ascii_o = "Q";
      {3'd5, 6'b000000}: ascii_o = "5";
      {3'd5, 6'b000001}: ascii_o = "4";
      {3'd5, 6'b000011}: ascii_o = "3";
      {3'd5, 6'b000111}: ascii_o = "2";
      {3'd5, 6'b001111}: ascii_o = "1";
      {3'd5, 6'b010000}: ascii_o = "6";
      {3'd5, 6'b011000}: ascii_o = "7";
      {3'd5, 6'b011100}: ascii_o = "8";
      {3'd5, 6'b011110}: ascii_o = "9";
      {3'd5, 6'b011111}: ascii_o = "0";
      default: hit_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/morse_symbol_sequencer.sv
// morse_symbol_sequencer: acknowledges Morse timing events, assembles characters, queues ASCII in a FIFO
//  clk, reset (sync, active-high); bus: master side of morse_symbol_sequencer_if
//  overflow_o  sticky, an entry was dropped on a full FIFO; err_count_o saturating undecodable count
//  Define MORSE_ERR_CHAR_EN to emit '?' for undecodable characters instead of dropping them.
module morse_symbol_sequencer
  import morse_symbol_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  morse_symbol_sequencer_if.master bus,
  output logic                    overflow_o,
  output logic [ERR_CNT_W-1:0]    err_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_e               state_q, state_d;
  logic [2:0]           len_q, len_d;
  logic [5:0]           bits_q, bits_d;
  logic                 gap_q, gap_d, word_q, word_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q;
  logic                 overflow_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 hit, bad, push, do_push, pop, err_inc;
  logic [7:0]           ascii, push_data;
  morse_symbol_sequencer_decode_rom u_rom (
    .len_i  (len_q),
    .bits_i (bits_q),
    .hit_o  (hit),
    .ascii_o(ascii)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    bits_d = bits_q;
    gap_d = gap_q;
    word_d = word_q;
    push = 1'b0;
    push_data = ASCII_SPACE;
    err_inc = 1'b0;
    bad = len_q > MORSE_MAX_ELEMS || !hit;
    case (state_q)
      IDLE: state_d = bus.writing ? SETTLE : IDLE;
      SETTLE: state_d = CAPTURE;
      CAPTURE: begin
        gap_d = bus.interchar | bus.interword;
        word_d = bus.interword;
        if (bus.dot | bus.dash) begin
          bits_d = {bits_q[4:0], bus.dash};
          len_d = (len_q == 3'd7) ? len_q : len_q + 3'd1;
        end
        state_d = WAIT_CLR;
      end
      WAIT_CLR: state_d = bus.writing ? WAIT_CLR : (gap_q ? EMIT_CHAR : IDLE);
      EMIT_CHAR: begin
        if (len_q != 3'd0) begin
          err_inc = bad;
`ifdef MORSE_ERR_CHAR_EN
          push = 1'b1;
          push_data = bad ? ASCII_QMARK : ascii;
`else
          push = !bad;
          push_data = ascii;
`endif
        end
        len_d = 3'd0;
        bits_d = 6'd0;
        state_d = (word_q && len_q != 3'd0) ? EMIT_SPACE : IDLE;
      end
      EMIT_SPACE: begin
        push = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign pop = bus.out_valid & bus.out_ready;
  assign do_push = push & (!cnt_q[AW] | pop);
  assign bus.read = state_q == CAPTURE;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_data = bus.out_valid ? mem_q[rd_q] : 8'h00;
  assign overflow_o = overflow_q;
  assign err_count_o = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= 3'd0;
      bits_q <= 6'd0;
      gap_q <= 1'b0;
      word_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      overflow_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      bits_q <= bits_d;
      gap_q <= gap_d;
      word_q <= word_d;
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
      overflow_q <= overflow_q | (push & !do_push);
      err_q <= (err_inc && !(&err_q)) ? err_q + 1'b1 : err_q;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end
endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// tb_morse_symbol_sequencer: scoreboard bench with a string-based Morse reference model
module tb_morse_symbol_sequencer;
  localparam int FIFO_DEPTH = 4;
  localparam int ERR_CNT_W  = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic overflow;
  logic [ERR_CNT_W-1:0] err_count;
  morse_symbol_sequencer_if bus ();
  morse_symbol_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .overflow_o (overflow),
    .err_count_o(err_count)
  );
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  byte exp_q[$];
  int exp_err = 0;
  bit exp_ovf = 0;
  string acc = "";
  bit rnd_ready = 0;
  bit fixed_ready = 1;
  string letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string code_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                           "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                           "..-", "...-", ".--", "-..-", "-.--", "--..",
                           "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                           "---..", "----."};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit lookup(string s, output byte c);
    for (int i = 0; i < 36; i++)
      if (code_tab[i] == s) begin
        c = letters.getc(i);
        return 1'b1;
      end
    c = 8'h00;
    return 1'b0;
  endfunction

  function automatic void model_push(byte c);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(c);
    else exp_ovf = 1'b1;
  endfunction

  // Reference behaviour: elements collect as a dot/dash string; a gap decodes it by table lookup.
  function automatic void model_event(bit d, bit da, bit ic, bit iw);
    byte c;
    if (da) acc = {acc, "-"};
    else if (d) acc = {acc, "."};
    if (ic || iw) begin
      if (acc.len() > 0) begin
        if (lookup(acc, c)) model_push(c);
        else begin
          if (exp_err < (1 << ERR_CNT_W) - 1) exp_err++;
`ifdef MORSE_ERR_CHAR_EN
          model_push(8'h3F);
`endif
        end
        if (iw) model_push(8'h20);
      end
      acc = "";
    end
  endfunction

  always @(posedge clk) begin
    #1;
    bus.out_ready = rnd_ready ? ($urandom_range(3) != 0) : fixed_ready;
  end

  logic [7:0] prev_data;
  bit prev_stall = 0;
  always @(negedge clk) begin
    if (reset) prev_stall = 0;
    else begin
      if (prev_stall) check("hold_stable", bus.out_data, prev_data);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", bus.out_data);
        end else check("out_data", bus.out_data, exp_q.pop_front());
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end

  task automatic send(bit d, bit da, bit ic, bit iw, bit rst_cap = 0);
    @(posedge clk); #1 bus.writing = 1'b1;
    @(posedge clk); #1 check("read_settle", bus.read, 0);
    bus.dot = d; bus.dash = da; bus.interchar = ic; bus.interword = iw;
    @(posedge clk); #1 check("read_capture", bus.read, 1);
    if (rst_cap) begin
      reset = 1'b1;
      @(posedge clk); #1 check("rst_read", bus.read, 0);
      check("rst_valid", bus.out_valid, 0);
      reset = 1'b0;
      acc = "";
      exp_q.delete();
      exp_err = 0;
      exp_ovf = 0;
    end else begin
      model_event(d, da, ic, iw);
      @(posedge clk); #1 check("read_single", bus.read, 0);
    end
    bus.writing = 1'b0; bus.dot = 1'b0; bus.dash = 1'b0; bus.interchar = 1'b0; bus.interword = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((bus.out_valid || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    string pat;
    int g;
    bus.writing = 1'b0; bus.dot = 1'b0; bus.dash = 1'b0; bus.interchar = 1'b0; bus.interword = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read0", bus.read, 0);
    check("rst_valid0", bus.out_valid, 0);
    check("rst_data0", bus.out_data, 0);
    check("rst_ovf0", overflow, 0);
    check("rst_err0", err_count, 0);
    reset = 1'b0;
    send(1, 0, 0, 0); send(0, 0, 1, 0);
    drain();
    send(0, 1, 0, 0); send(1, 0, 0, 0); send(0, 1, 0, 0); send(1, 0, 0, 0); send(0, 0, 0, 1);
    drain();
    fixed_ready = 0;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin send(1, 0, 0, 0); send(0, 0, 1, 0); end
    #1 check("t3_ovf", overflow, exp_ovf);
    check("t3_valid", bus.out_valid, 1);
    fixed_ready = 1;
    drain();
    check("t3_left", exp_q.size(), 0);
    for (int k = 0; k < 7; k++) send(1, 0, 0, 0);
    send(0, 0, 1, 0);
    drain();
    check("t4_err", err_count, exp_err);
    send(1, 0, 0, 0); send(0, 0, 0, 0); send(0, 1, 0, 0); send(0, 0, 1, 0);
    drain();
    send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 0, 0, 0, 1);
    check("t6_ovf", overflow, 0);
    check("t6_err", err_count, 0);
    send(1, 0, 0, 0); send(0, 0, 1, 0);
    drain();
    rnd_ready = 1;
    for (int k = 0; k < 40; k++) begin
      pat = "";
      if ($urandom_range(4) != 0) pat = code_tab[$urandom_range(35)];
      else for (int j = 0; j < int'($urandom_range(7, 1)); j++)
        if ($urandom_range(1) != 0) pat = {pat, "-"}; else pat = {pat, "."};
      for (int j = 0; j < pat.len(); j++) begin
        if ($urandom_range(5) == 0) send(0, 0, 0, 0);
        if (pat.getc(j) == 8'h2D) send($urandom_range(3) == 0, 1, 0, 0);
        else send(1, 0, 0, 0);
      end
      drain();
      g = $urandom_range(2);
      send(0, 0, g != 1, g != 0);
    end
    rnd_ready = 0;
    fixed_ready = 1;
    drain();
    check("final_err", err_count, exp_err);
    check("final_ovf", overflow, exp_ovf);
    check("final_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
